serial_packet_decoder: RTL

- Sits directly downstream of the serial receiver; consumes its received-byte output and its finish level.
- Frames the byte stream as SYNC, LEN, payload and CSUM, and buffers the payload internally.
- Releases the payload over a valid/ready stream only after the checksum passes. Corrupt, oversize or stalled packets are discarded and reported.

---
 rtl/serial_packet_decoder_pkg.sv | 11 +
 rtl/serial_pkt_buf.sv | 28 ++
 rtl/serial_packet_decoder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_packet_decoder_pkg.sv
// Shared definitions for the serial packet decoder.
// Holds the FSM state encodings used by the decoder top and its buffer.
package serial_packet_decoder_pkg;

    localparam logic [2:0] ST_SYNC    = 3'd0;
    localparam logic [2:0] ST_LEN     = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_CSUM    = 3'd3;
    localparam logic [2:0] ST_DRAIN   = 3'd4;

endpackage

// File: rtl/serial_pkt_buf.sv
// Payload buffer: MaxLen x Width register array.
// Ports: clk; we_i/waddr_i/wdata_i synchronous write; raddr_i/rdata_c_o
// combinational read.
module serial_pkt_buf
    import serial_packet_decoder_pkg::*;
#(
    parameter int unsigned Width  = 8,
    parameter int unsigned MaxLen = 16,
    parameter int unsigned IdxW   = $clog2(MaxLen)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IdxW-1:0]  waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [IdxW-1:0]  raddr_i,
    output logic [Width-1:0] rdata_c_o
);

    logic [Width-1:0] mem_q [MaxLen];

    // Contents carry no reset; only bytes written in the current packet are read.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/serial_packet_decoder.sv
// Serial packet decoder: frames SYNC, LEN, payload, CSUM from the receiver
// byte stream, buffers the payload and releases it over valid/ready once the
// checksum matches.
// Ports: clk, rst (async, active-high); rx_data/rx_finish from the receiver;
// out_data/out_valid/out_last/out_ready output stream; pkt_err and overrun
// one-cycle pulses; busy high outside SYNC.
module serial_packet_decoder
    import serial_packet_decoder_pkg::*;
#(
    parameter int unsigned      Width        = 8,
    parameter int unsigned      MaxLen       = 16,
    parameter logic [Width-1:0] SyncByte     = Width'(8'hA5),
    parameter int unsigned      TimeoutWidth = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] rx_data,
    input  logic             rx_finish,
    output logic [Width-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             pkt_err,
    output logic             overrun,
    output logic             busy
);

    localparam int unsigned IdxW = $clog2(MaxLen);
    localparam int unsigned LenW = $clog2(MaxLen + 1);
    localparam logic [TimeoutWidth-1:0] TmoOnes = '1;

    logic [2:0]              state_q, state_d;
    logic                    fin_q, ev_q;
    logic [Width-1:0]        data_q;
    logic [LenW-1:0]         len_q, len_d;
    logic [IdxW-1:0]         idx_q, idx_d, rd_q, rd_d, rd_addr;
    logic [Width-1:0]        csum_q, csum_d;
    logic [TimeoutWidth-1:0] tmo_q, tmo_d;
    logic                    tmo_fire;
    logic                    buf_we;
    logic [Width-1:0]        buf_rdata;
    logic [Width-1:0]        out_data_d;
    logic                    out_valid_d, out_last_d, pkt_err_d, overrun_d, busy_d;
    logic                    byte_ev;

    // Rising edge of the finish level marks a completed byte.
    assign byte_ev = rx_finish & ~fin_q;

    // Read ahead of the output register: index 0 while entering DRAIN, rd+1 during it.
    assign rd_addr = (state_q == ST_DRAIN) ? rd_q + IdxW'(1) : '0;

    serial_pkt_buf #(
        .Width  (Width),
        .MaxLen (MaxLen),
        .IdxW   (IdxW)
    ) u_buf (
        .clk       (clk),
        .we_i      (buf_we),
        .waddr_i   (idx_q),
        .wdata_i   (data_q),
        .raddr_i   (rd_addr),
        .rdata_c_o (buf_rdata)
    );

    // Edge detect, byte capture and all registered state/outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fin_q     <= 1'b1;
            ev_q      <= 1'b0;
            data_q    <= '0;
            state_q   <= ST_SYNC;
            len_q     <= '0;
            idx_q     <= '0;
            rd_q      <= '0;
            csum_q    <= '0;
            tmo_q     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            pkt_err   <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            fin_q     <= rx_finish;
            ev_q      <= byte_ev;
            if (byte_ev) data_q <= rx_data;
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            rd_q      <= rd_d;
            csum_q    <= csum_d;
            tmo_q     <= tmo_d;
            out_data  <= out_data_d;
            out_valid <= out_valid_d;
            out_last  <= out_last_d;
            pkt_err   <= pkt_err_d;
            overrun   <= overrun_d;
            busy      <= busy_d;
        end
    end

    // Next-state and output logic; the registered byte (ev_q/data_q) drives the FSM.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        rd_d        = rd_q;
        csum_d      = csum_q;
        tmo_d       = tmo_q;
        tmo_fire    = 1'b0;
        buf_we      = 1'b0;
        out_data_d  = out_data;
        out_valid_d = out_valid;
        out_last_d  = out_last;
        pkt_err_d   = 1'b0;
        overrun_d   = 1'b0;

        // A raw byte event always clears the counter, so it beats saturation.
        if (byte_ev) begin
            tmo_d = '0;
        end else if (state_q == ST_LEN || state_q == ST_PAYLOAD || state_q == ST_CSUM) begin
            tmo_d    = tmo_q + TimeoutWidth'(1);
            tmo_fire = (tmo_q == TmoOnes - TimeoutWidth'(1));
        end

        case (state_q)
            ST_SYNC: begin
                if (ev_q && data_q == SyncByte) begin
                    state_d = ST_LEN;
                    tmo_d   = '0;
                end
            end
            ST_LEN: begin
                if (ev_q) begin
                    if (data_q == '0 || data_q > Width'(MaxLen)) begin
                        pkt_err_d = 1'b1;
                        state_d   = ST_SYNC;
                    end else begin
                        len_d   = LenW'(data_q);
                        csum_d  = data_q;
                        idx_d   = '0;
                        state_d = ST_PAYLOAD;
                    end
                end else if (tmo_fire) begin
                    pkt_err_d = 1'b1;
                    state_d   = ST_SYNC;
                end
            end
            ST_PAYLOAD: begin
                if (ev_q) begin
                    buf_we = 1'b1;
                    csum_d = csum_q + data_q;
                    idx_d  = idx_q + IdxW'(1);
                    if (LenW'(idx_q) == len_q - LenW'(1)) state_d = ST_CSUM;
                end else if (tmo_fire) begin
                    pkt_err_d = 1'b1;
                    state_d   = ST_SYNC;
                end
            end
            ST_CSUM: begin
                if (ev_q) begin
                    if (data_q == csum_q) begin
                        state_d     = ST_DRAIN;
                        rd_d        = '0;
                        out_valid_d = 1'b1;
                        out_data_d  = buf_rdata;
                        out_last_d  = (len_q == LenW'(1));
                    end else begin
                        pkt_err_d = 1'b1;
                        state_d   = ST_SYNC;
                    end
                end else if (tmo_fire) begin
                    pkt_err_d = 1'b1;
                    state_d   = ST_SYNC;
                end
            end
            ST_DRAIN: begin
                if (ev_q) overrun_d = 1'b1;
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = ST_SYNC;
                    end else begin
                        rd_d       = rd_q + IdxW'(1);
                        out_data_d = buf_rdata;
                        out_last_d = (LenW'(rd_q) + LenW'(1)) == (len_q - LenW'(1));
                    end
                end
            end
            default: begin
                state_d     = ST_SYNC;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_SYNC);
    end

endmodule
